// File: rtl/sel_mux_pipe_pkg.sv
// Shared definitions for the sel_mux_pipe selector: mode encodings,
// size limits and the channel-slice extraction helper.
package sel_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Upper bounds the slice helper is sized for (N up to 16, WIDTH up to 32).
  localparam int MAX_N   = 16;
  localparam int MAX_W   = 32;
  localparam int MAX_BUS = MAX_N * MAX_W;

  // Returns channel idx of a packed bus of w-bit channels; caller keeps the
  // low w bits of the result.
  function automatic logic [MAX_W-1:0] chan_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int unsigned       idx,
                                                  input int unsigned       w);
    logic [MAX_BUS-1:0] sh;
    sh = bus >> (idx * w);
    return sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Handshake/data bundle between the channel sources, the selector and the
// consumer. slave = selector side, master = source/consumer side.
// With SEL_MUX_PIPE_PARITY_EN defined the bundle carries out_par as well.
interface sel_mux_pipe_if #(
  parameter int WIDTH = 4,
  parameter int N     = 8
);
  localparam int SEL_W = $clog2(N);

  logic                 mode;
  logic [SEL_W-1:0]     sel;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_chan;
  logic                 out_valid;
  logic                 out_ready;
`ifdef SEL_MUX_PIPE_PARITY_EN
  logic                 out_par;

  modport slave  (input  mode, sel, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_chan, out_valid, out_par);
  modport master (output mode, sel, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_chan, out_valid, out_par);
`else
  modport slave  (input  mode, sel, in_data, in_valid, out_ready,
                  output in_ready, out_data, out_chan, out_valid);
  modport master (output mode, sel, in_data, in_valid, out_ready,
                  input  in_ready, out_data, out_chan, out_valid);
`endif

endinterface

// File: rtl/sel_mux_pipe_rr_pick.sv
// Rotating-priority finder: first asserted req starting at ptr, wrapping
// N-1 -> 0. Purely combinational.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int SEL_W = $clog2(N);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(j);
      end
    end
  end

endmodule

// File: rtl/sel_mux_pipe.sv
// N-to-1 selector with one registered output stage and valid/ready on both
// sides. Fixed mode picks channel sel; round-robin mode rotates over valid
// channels. Defining SEL_MUX_PIPE_PARITY_EN adds a registered even-parity
// bit (out_par) alongside out_data.
module sel_mux_pipe
  import sel_mux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 8
) (
  input logic             clk,
  input logic             reset,
  sel_mux_pipe_if.slave   bus
);
  localparam int SEL_W = $clog2(N);

  logic             load;
  logic             fx_valid;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             grant_valid;
  logic [SEL_W-1:0] grant;
  logic             xfer;
  logic [MAX_W-1:0] slice_full;
  logic [WIDTH-1:0] sel_data;

  logic [SEL_W-1:0] rr_ptr;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;
  logic             vld_q;

  // Register is free when empty or being drained this cycle.
  assign load = !vld_q | bus.out_ready;

  // Out-of-range sel never grants (matters when N is not a power of two).
  assign fx_valid = (32'(bus.sel) < N) && bus.in_valid[bus.sel];

  rr_pick #(.N(N)) u_pick (
    .req       (bus.in_valid),
    .ptr       (rr_ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign grant_valid = (bus.mode == MODE_RR) ? rr_valid : fx_valid;
  assign grant       = (bus.mode == MODE_RR) ? rr_idx   : bus.sel;

  // No transfer may complete while reset is asserted.
  assign xfer = load & grant_valid & !reset;

  assign slice_full = chan_slice(MAX_BUS'(bus.in_data), 32'(grant), WIDTH);
  assign sel_data   = slice_full[WIDTH-1:0];

  // One-hot ready toward the granted channel only.
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign bus.in_ready[i] = xfer & (grant == SEL_W'(i));
  end

  // Output register: reload on transfer, clear valid on a bare drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      chan_q <= '0;
    end else if (xfer) begin
      vld_q  <= 1'b1;
      data_q <= sel_data;
      chan_q <= grant;
    end else if (bus.out_ready) begin
      vld_q  <= 1'b0;
    end
  end

  // Round-robin pointer moves past the winner on round-robin transfers only.
  always_ff @(posedge clk) begin
    if (reset)
      rr_ptr <= '0;
    else if (xfer && bus.mode == MODE_RR)
      rr_ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = vld_q;

`ifdef SEL_MUX_PIPE_PARITY_EN
  logic par_q;

  // Parity bit travels with the data word it was computed from.
  always_ff @(posedge clk) begin
    if (reset)     par_q <= 1'b0;
    else if (xfer) par_q <= ^sel_data;
  end

  assign bus.out_par = par_q;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Directed bench for sel_mux_pipe: an N=8 instance for the main scenarios
// and an N=12 instance for select range behaviour.
module tb_sel_mux_pipe;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sel_mux_pipe_if #(.WIDTH(4), .N(8))  ba ();
  sel_mux_pipe_if #(.WIDTH(4), .N(12)) bb ();

  logic [7:0][3:0]  ch_a;
  logic [11:0][3:0] ch_b;
  assign ba.in_data = ch_a;
  assign bb.in_data = ch_b;

  sel_mux_pipe #(.WIDTH(4), .N(8))  dut_a (.clk(clk), .reset(reset), .bus(ba));
  sel_mux_pipe #(.WIDTH(4), .N(12)) dut_b (.clk(clk), .reset(reset), .bus(bb));

  task automatic test_reset();
    reset = 1'b1;
    ba.mode = 1'b0; ba.sel = 3'd0; ba.in_valid = 8'hFF; ba.out_ready = 1'b1;
    bb.mode = 1'b0; bb.sel = 4'd0; bb.in_valid = 12'h000; bb.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) ch_a[i] = 4'hF - 4'(i);
    for (int i = 0; i < 12; i++) ch_b[i] = 4'(i);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (ba.out_valid !== 1'b0 || ba.in_ready !== 8'h00 ||
          ba.out_data !== 4'h0 || ba.out_chan !== 3'd0) begin
        errors++;
        $display("FAIL reset_state cyc%0d: valid=%b rdy=%h data=%h chan=%0d, want 0/00/0/0",
                 c, ba.out_valid, ba.in_ready, ba.out_data, ba.out_chan);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ba.in_ready !== 8'h01) begin
      errors++; $display("FAIL reset_first_rdy: got %h want 01", ba.in_ready);
    end
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b1 || ba.out_chan !== 3'd0 || ba.out_data !== 4'hF) begin
      errors++;
      $display("FAIL reset_first_xfer: valid=%b chan=%0d data=%h, want 1/0/F",
               ba.out_valid, ba.out_chan, ba.out_data);
    end
  endtask

  task automatic test_fixed();
    ba.mode = 1'b0; ba.sel = 3'd3; ba.in_valid = 8'h08; ch_a[3] = 4'hA;
    #1;
    checks++;
    if (ba.in_ready !== 8'h08) begin
      errors++; $display("FAIL fixed_rdy: got %h want 08", ba.in_ready);
    end
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b1 || ba.out_chan !== 3'd3 || ba.out_data !== 4'hA) begin
      errors++;
      $display("FAIL fixed_out: valid=%b chan=%0d data=%h, want 1/3/A",
               ba.out_valid, ba.out_chan, ba.out_data);
    end
    ba.in_valid = 8'hF7;
    #1;
    checks++;
    if (ba.in_ready !== 8'h00) begin
      errors++; $display("FAIL fixed_sel_invalid_rdy: got %h want 00", ba.in_ready);
    end
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b0 || ba.out_data !== 4'hA || ba.out_chan !== 3'd3) begin
      errors++;
      $display("FAIL fixed_drain: valid=%b data=%h chan=%0d, want 0/A/3",
               ba.out_valid, ba.out_data, ba.out_chan);
    end
    ba.in_valid = 8'h00;
  endtask

  task automatic test_fixed_range();
    bb.mode = 1'b0; bb.sel = 4'd9; bb.in_valid = 12'hDFF;
    #1;
    checks++;
    if (bb.in_ready !== 12'h000) begin
      errors++; $display("FAIL range_ch9_invalid: got %h want 000", bb.in_ready);
    end
    bb.sel = 4'd13; bb.in_valid = 12'hFFF;
    #1;
    checks++;
    if (bb.in_ready !== 12'h000) begin
      errors++; $display("FAIL range_sel_ge_n: got %h want 000", bb.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bb.out_valid !== 1'b0) begin
      errors++; $display("FAIL range_no_out: valid=%b want 0", bb.out_valid);
    end
    bb.sel = 4'd9;
    #1;
    checks++;
    if (bb.in_ready !== 12'h200) begin
      errors++; $display("FAIL range_ch9_rdy: got %h want 200", bb.in_ready);
    end
    @(negedge clk);
    checks++;
    if (bb.out_valid !== 1'b1 || bb.out_chan !== 4'd9 || bb.out_data !== 4'h9) begin
      errors++;
      $display("FAIL range_ch9_out: valid=%b chan=%0d data=%h, want 1/9/9",
               bb.out_valid, bb.out_chan, bb.out_data);
    end
    bb.in_valid = 12'h000;
  endtask

  task automatic test_back_to_back();
    int exp_ch[6] = '{0, 2, 5, 7, 0, 2};
    for (int i = 0; i < 8; i++) ch_a[i] = 4'(i) ^ 4'h9;
    ba.mode = 1'b1; ba.in_valid = 8'b1010_0101; ba.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      checks++;
      if (ba.in_ready !== 8'(1 << exp_ch[k])) begin
        errors++;
        $display("FAIL rr_rdy[%0d]: got %h want %h", k, ba.in_ready, 8'(1 << exp_ch[k]));
      end
      @(negedge clk);
      checks++;
      if (ba.out_valid !== 1'b1 || ba.out_chan !== 3'(exp_ch[k]) ||
          ba.out_data !== (4'(exp_ch[k]) ^ 4'h9)) begin
        errors++;
        $display("FAIL rr_out[%0d]: valid=%b chan=%0d data=%h, want 1/%0d/%h", k,
                 ba.out_valid, ba.out_chan, ba.out_data, exp_ch[k], 4'(exp_ch[k]) ^ 4'h9);
      end
    end
    ba.in_valid = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    ba.mode = 1'b0; ba.sel = 3'd2; ch_a[2] = 4'h5; ch_a[1] = 4'h6;
    ba.in_valid = 8'h04; ba.out_ready = 1'b1;
    @(negedge clk);
    ba.out_ready = 1'b0; ba.sel = 3'd1; ba.in_valid = 8'h02;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (ba.in_ready !== 8'h00) begin
        errors++; $display("FAIL bp_rdy[%0d]: got %h want 00", c, ba.in_ready);
      end
      @(negedge clk);
      checks++;
      if (ba.out_valid !== 1'b1 || ba.out_data !== 4'h5 || ba.out_chan !== 3'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h chan=%0d, want 1/5/2",
                 c, ba.out_valid, ba.out_data, ba.out_chan);
      end
    end
    ba.out_ready = 1'b1;
    #1;
    checks++;
    if (ba.in_ready !== 8'h02) begin
      errors++; $display("FAIL bp_release_rdy: got %h want 02", ba.in_ready);
    end
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b1 || ba.out_data !== 4'h6 || ba.out_chan !== 3'd1) begin
      errors++;
      $display("FAIL bp_release_out: valid=%b data=%h chan=%0d, want 1/6/1",
               ba.out_valid, ba.out_data, ba.out_chan);
    end
    ba.in_valid = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    // Round-robin pointer is at 3 here; granting ch0 moves it to 1.
    ba.mode = 1'b1; ch_a[0] = 4'hC; ba.in_valid = 8'h01; ba.out_ready = 1'b1;
    @(negedge clk);
    ba.in_valid = 8'h00; ba.out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b1 || ba.out_data !== 4'hC) begin
      errors++;
      $display("FAIL mid_held: valid=%b data=%h, want 1/C", ba.out_valid, ba.out_data);
    end
    reset = 1'b1; ba.in_valid = 8'h81; ba.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b0 || ba.out_data !== 4'h0 || ba.in_ready !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h rdy=%h, want 0/0/00",
               ba.out_valid, ba.out_data, ba.in_ready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (ba.in_ready !== 8'h01) begin
      errors++; $display("FAIL mid_ptr_rdy: got %h want 01", ba.in_ready);
    end
    @(negedge clk);
    checks++;
    if (ba.out_valid !== 1'b1 || ba.out_chan !== 3'd0 || ba.out_data !== 4'hC) begin
      errors++;
      $display("FAIL mid_after: valid=%b chan=%0d data=%h, want 1/0/C",
               ba.out_valid, ba.out_chan, ba.out_data);
    end
    ba.in_valid = 8'h00;
    @(negedge clk);
  endtask

`ifdef SEL_MUX_PIPE_PARITY_EN
  task automatic test_parity();
    ba.mode = 1'b0; ba.sel = 3'd0; ch_a[0] = 4'b0111; ba.in_valid = 8'h01; ba.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ba.out_par !== 1'b1 || ba.out_data !== 4'b0111) begin
      errors++; $display("FAIL par_odd: par=%b data=%h, want 1/7", ba.out_par, ba.out_data);
    end
    ch_a[0] = 4'b0110;
    @(negedge clk);
    checks++;
    if (ba.out_par !== 1'b0 || ba.out_data !== 4'b0110) begin
      errors++; $display("FAIL par_even: par=%b data=%h, want 0/6", ba.out_par, ba.out_data);
    end
    ba.in_valid = 8'h00;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_fixed();
    test_fixed_range();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef SEL_MUX_PIPE_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
